morty_ex_stage_md: RTL

- Parametrised successor EX stage.
- Combinational ALU path plus an iterative RV-M multiply/divide unit. Results are registered into an EX/MEM pipeline register.
- Sits between ID/EX and MEM. Drives a busy stall back to the hazard unit while a multi-cycle M operation runs.
- Sideband fields (flags, CSR, exception info) travel in one generic SB_W-wide bus, registered alongside the result.

---
 rtl/morty_ex_stage_md.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/morty_ex_stage_md.sv
// EX stage: combinational ALU plus an iterative RV-M multiply/divide unit feeding the EX/MEM register.
// Optional build macro MORTY_FAST_MUL_EN: multiplies use a single-cycle combinational product.

module morty_exu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] res_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B
  always_comb begin
    res_o = '0;
    case (op_i)
      4'd0:    res_o = a_i + b_i;
      4'd1:    res_o = a_i - b_i;
      4'd2:    res_o = a_i << shamt;
      4'd3:    res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      4'd4:    res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      4'd5:    res_o = a_i ^ b_i;
      4'd6:    res_o = a_i >> shamt;
      4'd7:    res_o = $signed(a_i) >>> shamt;
      4'd8:    res_o = a_i | b_i;
      4'd9:    res_o = a_i & b_i;
      4'd10:   res_o = b_i;
      default: res_o = '0;
    endcase
  end
endmodule

module morty_ex_stage_md #(
  parameter int XLEN  = 32,
  parameter int SB_W  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_stall_i,
  input  logic            mem_flush_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_port_a_i,
  input  logic [XLEN-1:0] ex_port_b_i,
  input  logic [3:0]      ex_alu_op_i,
  input  logic            ex_md_en_i,
  input  logic [2:0]      ex_md_op_i,
  input  logic [4:0]      ex_waddr_i,
  input  logic            ex_we_i,
  input  logic [SB_W-1:0] ex_sb_i,
  output logic            ex_busy_o,
  output logic [XLEN-1:0] ex_fwd_dat_o,
  output logic            ex_fwd_valid_o,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic [4:0]      mem_waddr_o,
  output logic            mem_we_o,
  output logic [SB_W-1:0] mem_sb_o
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;

  logic              mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]   mem_pc_q, mem_pc_d;
  logic [XLEN-1:0]   mem_result_q, mem_result_d;
  logic [4:0]        mem_waddr_q, mem_waddr_d;
  logic              mem_we_q, mem_we_d;
  logic [SB_W-1:0]   mem_sb_q, mem_sb_d;

  logic [XLEN-1:0]   alu_res;
  logic              md_is_div, signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic              fast_mul, md_start, md_done, load_valid;
  logic [XLEN-1:0]   fast_res, md_res;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  morty_exu #(.XLEN(XLEN)) u_exu (
    .a_i   (ex_port_a_i),
    .b_i   (ex_port_b_i),
    .op_i  (ex_alu_op_i),
    .res_o (alu_res)
  );

  // Operand signedness and magnitudes; MUL low half is sign-agnostic so it is treated as unsigned.
  assign md_is_div = ex_md_op_i[2];
  assign signed_a  = md_is_div ? ~ex_md_op_i[0] : ((ex_md_op_i == 3'd1) | (ex_md_op_i == 3'd2));
  assign signed_b  = md_is_div ? ~ex_md_op_i[0] : (ex_md_op_i == 3'd1);
  assign a_neg     = signed_a & ex_port_a_i[XLEN-1];
  assign b_neg     = signed_b & ex_port_b_i[XLEN-1];
  assign a_mag     = a_neg ? -ex_port_a_i : ex_port_a_i;
  assign b_mag     = b_neg ? -ex_port_b_i : ex_port_b_i;
  assign div_zero  = md_is_div & (ex_port_b_i == '0);
  assign div_ovf   = md_is_div & ~ex_md_op_i[0] & (ex_port_a_i == XMIN) & (ex_port_b_i == '1);

`ifdef MORTY_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_mul  = ex_md_en_i & ~ex_md_op_i[2];
  assign fast_a    = signed_a ? {{XLEN{ex_port_a_i[XLEN-1]}}, ex_port_a_i} : {{XLEN{1'b0}}, ex_port_a_i};
  assign fast_b    = signed_b ? {{XLEN{ex_port_b_i[XLEN-1]}}, ex_port_b_i} : {{XLEN{1'b0}}, ex_port_b_i};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (ex_md_op_i == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul  = 1'b0;
  assign fast_res  = '0;
`endif

  assign md_start  = (state_q == ST_IDLE) & ex_valid_i & ex_md_en_i & ~fast_mul;
  assign md_done   = (state_q == ST_DONE);
  assign ex_busy_o = md_start | (state_q == ST_BUSY);

  // One iteration step for each unit: shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_q};
  end

  // FSM next-state and iteration datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    if (mem_flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start) begin
            op_d = ex_md_op_i;
            if (div_zero) begin
              lo_d      = '1;
              acc_d     = ex_port_a_i;
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = ST_DONE;
            end else if (div_ovf) begin
              lo_d      = ex_port_a_i;
              acc_d     = '0;
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = ST_DONE;
            end else begin
              acc_d     = '0;
              lo_d      = a_mag;
              opb_d     = b_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              cnt_d     = CNT_INIT;
              state_d   = ST_BUSY;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (op_q[2]) begin
            acc_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (!mem_stall_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sign fixup and result selection for a finished M operation.
  always_comb begin
    prod_raw = {acc_q, lo_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
    case (op_q)
      3'd0:              md_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  md_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:        md_res = quo_fix;
      3'd6, 3'd7:        md_res = rem_fix;
      default:           md_res = '0;
    endcase
  end

  assign ex_fwd_valid_o = ~ex_md_en_i | md_done | fast_mul;
  assign ex_fwd_dat_o   = ~ex_md_en_i ? alu_res : (md_done ? md_res : fast_res);
  assign load_valid     = ex_valid_i & ~ex_busy_o;

  // EX/MEM register: flush beats stall, stall holds, otherwise load (bubble while busy).
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_pc_d     = mem_pc_q;
    mem_result_d = mem_result_q;
    mem_waddr_d  = mem_waddr_q;
    mem_we_d     = mem_we_q;
    mem_sb_d     = mem_sb_q;
    if (mem_flush_i) begin
      mem_valid_d = 1'b0;
      mem_we_d    = 1'b0;
    end else if (mem_stall_i) begin
      mem_valid_d = mem_valid_q;
    end else begin
      mem_valid_d  = load_valid;
      mem_pc_d     = ex_pc_i;
      mem_result_d = ex_fwd_dat_o;
      mem_waddr_d  = ex_waddr_i;
      mem_we_d     = ex_we_i & load_valid;
      mem_sb_d     = ex_sb_i;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      lo_q         <= '0;
      opb_q        <= '0;
      op_q         <= 3'd0;
      neg_q        <= 1'b0;
      neg_rem_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_pc_q     <= '0;
      mem_result_q <= '0;
      mem_waddr_q  <= 5'd0;
      mem_we_q     <= 1'b0;
      mem_sb_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      lo_q         <= lo_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      neg_rem_q    <= neg_rem_d;
      mem_valid_q  <= mem_valid_d;
      mem_pc_q     <= mem_pc_d;
      mem_result_q <= mem_result_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_we_q     <= mem_we_d;
      mem_sb_q     <= mem_sb_d;
    end
  end

  assign mem_valid_o  = mem_valid_q;
  assign mem_pc_o     = mem_pc_q;
  assign mem_result_o = mem_result_q;
  assign mem_waddr_o  = mem_waddr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_sb_o     = mem_sb_q;
endmodule
